riscv_kernel_host_ctrl: RTL and testbench

//  Host-side controller for the riscv_kernel ap_ctrl handshake. It loads a golden result

---
 rtl/riscv_kernel_host_ctrl.sv | 157 +++++++++++++++
 tb/tb_riscv_kernel_host_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_kernel_host_ctrl.sv
// Host-side ap_ctrl launcher and dmem readback checker for riscv_kernel.
// Holds ap_start until ap_done, then streams N_WORDS reads and compares them against a golden table.
module riscv_kernel_host_ctrl #(
  parameter int unsigned AWIDTH  = 5,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned N_WORDS = 10,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              run,
  input  logic              gold_we,
  input  logic [AWIDTH-1:0] gold_addr,
  input  logic [DWIDTH-1:0] gold_d,
  output logic              k_ap_start,
  input  logic              k_ap_done,
  output logic [AWIDTH-1:0] rb_address0,
  output logic              rb_ce0,
  input  logic [DWIDTH-1:0] rb_q0,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [AWIDTH:0]   err_cnt,
  output logic [AWIDTH-1:0] first_err_addr
);

  localparam int unsigned EW    = AWIDTH + 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned DEPTH = 2 ** AWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_READ,
    S_FLUSH,
    S_REPORT
  } state_e;

  state_e            state_q;
  logic [DWIDTH-1:0] gold_q [DEPTH];
  logic [TW-1:0]     tmo_cnt_q;
  logic              cmp_vld_q;
  logic [AWIDTH-1:0] cmp_tag_q;
  logic              k_ap_start_q;
  logic              rb_ce0_q;
  logic [AWIDTH-1:0] rb_address0_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;
  logic [EW-1:0]     err_cnt_q;
  logic [AWIDTH-1:0] first_err_addr_q;
  logic              mismatch;

  assign k_ap_start     = k_ap_start_q;
  assign rb_ce0         = rb_ce0_q;
  assign rb_address0    = rb_address0_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;

  // rb_q0 is tagged by the address issued one cycle earlier
  assign mismatch = cmp_vld_q && (rb_q0 != gold_q[cmp_tag_q]);

  // Golden table is not reset; writes only land while idle
  always_ff @(posedge ap_clk) begin
    if (state_q == S_IDLE && gold_we) begin
      gold_q[gold_addr] <= gold_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q          <= S_IDLE;
      tmo_cnt_q        <= '0;
      cmp_vld_q        <= 1'b0;
      cmp_tag_q        <= '0;
      k_ap_start_q     <= 1'b0;
      rb_ce0_q         <= 1'b0;
      rb_address0_q    <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
    end else begin
      done_q    <= 1'b0;
      cmp_vld_q <= rb_ce0_q;
      cmp_tag_q <= rb_address0_q;

      if (mismatch) begin
        if (err_cnt_q == '0) begin
          first_err_addr_q <= cmp_tag_q;
        end
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + EW'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (run) begin
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            tmo_cnt_q        <= '0;
            k_ap_start_q     <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (k_ap_done) begin
            k_ap_start_q  <= 1'b0;
            rb_ce0_q      <= 1'b1;
            rb_address0_q <= '0;
            state_q       <= S_READ;
          end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            timeout_q    <= 1'b1;
            k_ap_start_q <= 1'b0;
            state_q      <= S_REPORT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        S_READ: begin
          if (rb_address0_q == AWIDTH'(N_WORDS - 1)) begin
            rb_ce0_q      <= 1'b0;
            rb_address0_q <= '0;
            state_q       <= S_FLUSH;
          end else begin
            rb_address0_q <= rb_address0_q + AWIDTH'(1);
          end
        end
        S_FLUSH: begin
          state_q <= S_REPORT;
        end
        S_REPORT: begin
          pass_q  <= (err_cnt_q == '0) && !timeout_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_kernel_host_ctrl.sv
// Bench for riscv_kernel_host_ctrl: directed scenarios plus randomized runs against a
// behavioural readback model (golden table, dmem image, kernel with programmable ap_done delay).
module tb_riscv_kernel_host_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 10;
  localparam int unsigned TMO = 64;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          run = 1'b0;
  logic          gold_we = 1'b0;
  logic [AW-1:0] gold_addr = '0;
  logic [DW-1:0] gold_d = '0;
  logic          k_ap_done = 1'b0;
  logic          k_ap_start, rb_ce0, busy, done, pass, timeout;
  logic [AW-1:0] rb_address0, first_err_addr;
  logic [DW-1:0] rb_q0;
  logic [AW:0]   err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] gold_m [32];
  logic [DW-1:0] dmem   [32];
  logic [DW-1:0] tbl    [10] = '{32'h1, 32'h5, 32'h8, 32'h7, 32'h2, 32'hd, 32'h18, 32'h6, 32'h3, 32'h2c};

  int            start_cycles = 0;
  int            ce_cnt = 0;
  logic [AW-1:0] ce_log [256];

  riscv_kernel_host_ctrl #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .N_WORDS(NW),
    .TIMEOUT(TMO)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .run           (run),
    .gold_we       (gold_we),
    .gold_addr     (gold_addr),
    .gold_d        (gold_d),
    .k_ap_start    (k_ap_start),
    .k_ap_done     (k_ap_done),
    .rb_address0   (rb_address0),
    .rb_ce0        (rb_ce0),
    .rb_q0         (rb_q0),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr)
  );

  always #5 ap_clk = ~ap_clk;

  // dmem model with 1-cycle read latency; garbage on idle cycles
  always @(posedge ap_clk) begin
    if (k_ap_start) start_cycles <= start_cycles + 1;
    if (rb_ce0) begin
      ce_log[ce_cnt % 256] <= rb_address0;
      ce_cnt               <= ce_cnt + 1;
      rb_q0                <= dmem[rb_address0];
    end else begin
      rb_q0 <= DW'($urandom());
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gwrite(input int a, input logic [DW-1:0] v);
    @(negedge ap_clk);
    gold_we   = 1'b1;
    gold_addr = AW'(a);
    gold_d    = v;
    @(negedge ap_clk);
    gold_we   = 1'b0;
    gold_m[a] = v;
  endtask

  // d<0: kernel never finishes. mode 1: run+gold_we pulsed mid-READ. mode 2: reset mid-READ.
  task automatic do_run(input int d, input int mode);
    int s0, c0, k, exp_err, exp_first;
    bit seq_ok;
    exp_err   = 0;
    exp_first = 0;
    for (int i = 0; i < NW; i++) begin
      if (dmem[i] !== gold_m[i]) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    s0 = start_cycles;
    c0 = ce_cnt;
    @(negedge ap_clk);
    run = 1'b1;
    @(negedge ap_clk);
    run = 1'b0;
    chk("launch_start", 64'(k_ap_start), 64'd1);
    chk("launch_busy", 64'(busy), 64'd1);

    if (d < 0) begin
      k = 0;
      while (!done && k < 200) begin
        @(negedge ap_clk);
        k++;
      end
      chk("tmo_done_seen", 64'(done), 64'd1);
      chk("tmo_flag", 64'(timeout), 64'd1);
      chk("tmo_pass", 64'(pass), 64'd0);
      chk("tmo_start_cycles", 64'(start_cycles - s0), 64'(TMO));
      chk("tmo_no_readback", 64'(ce_cnt - c0), 64'd0);
      return;
    end

    repeat (d) @(negedge ap_clk);
    k_ap_done = 1'b1;
    @(negedge ap_clk);
    k_ap_done = 1'b0;
    chk("start_cycles", 64'(start_cycles - s0), 64'(d + 1));
    chk("first_issue", 64'({k_ap_start, rb_ce0, rb_address0}), 64'({1'b0, 1'b1, 5'd0}));

    k = 0;
    while (!done && k < 40) begin
      if (mode == 1 && k == 2) begin
        run = 1'b1; gold_we = 1'b1; gold_addr = '0; gold_d = 32'h99;
      end
      if (mode == 1 && k == 3) begin
        run = 1'b0; gold_we = 1'b0;
      end
      if (mode == 2 && k == 3) ap_rst = 1'b1;
      if (mode == 2 && k == 4) begin
        ap_rst = 1'b0;
        chk("rst_rb_ce0", 64'(rb_ce0), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_start", 64'(k_ap_start), 64'd0);
        return;
      end
      @(negedge ap_clk);
      k++;
    end
    chk("done_latency", 64'(k), 64'(NW + 2));
    chk("pass", 64'(pass), 64'(exp_err == 0));
    chk("err_cnt", 64'(err_cnt), 64'(exp_err));
    chk("first_err_addr", 64'(first_err_addr), 64'(exp_first));
    chk("timeout_clear", 64'(timeout), 64'd0);
    chk("rb_issue_count", 64'(ce_cnt - c0), 64'(NW));
    seq_ok = 1'b1;
    for (int i = 0; i < NW; i++) if (ce_log[(c0 + i) % 256] !== AW'(i)) seq_ok = 1'b0;
    chk("rb_addr_seq", 64'(seq_ok), 64'd1);
    @(negedge ap_clk);
    chk("done_pulse_end", 64'({done, busy}), 64'd0);
    if (mode == 1) begin
      repeat (5) @(negedge ap_clk);
      chk("ignored_run_idle", 64'(busy), 64'd0);
      chk("ignored_run_start", 64'(start_cycles - s0), 64'(d + 1));
    end
  endtask

  initial begin
    repeat (3) @(negedge ap_clk);
    chk("reset_ctrl", 64'({k_ap_start, rb_ce0, busy, done, pass, timeout}), 64'd0);
    chk("reset_cnt", 64'({rb_address0, err_cnt, first_err_addr}), 64'd0);
    ap_rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      gold_m[i] = '0;
      dmem[i]   = '0;
    end
    for (int i = 0; i < NW; i++) gwrite(i, tbl[i]);
    for (int i = 0; i < NW; i++) dmem[i] = tbl[i];

    // ap_done while idle must not start anything
    @(negedge ap_clk);
    k_ap_done = 1'b1;
    @(negedge ap_clk);
    k_ap_done = 1'b0;
    @(negedge ap_clk);
    chk("idle_done_ignored", 64'({busy, k_ap_start}), 64'd0);

    do_run(20, 0);

    dmem[4] = 32'h3;
    dmem[9] = 32'h0;
    do_run(20, 0);
    chk("mism_err_cnt", 64'(err_cnt), 64'd2);
    chk("mism_first", 64'(first_err_addr), 64'd4);
    dmem[4] = tbl[4];
    dmem[9] = tbl[9];

    do_run(-1, 0);
    do_run(0, 0);
    do_run(5, 1);
    do_run(7, 2);
    do_run(10, 0);
    chk("after_reset_pass", 64'(pass), 64'd1);

    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 2; w++) gwrite(int'($urandom_range(0, NW - 1)), DW'($urandom()));
      for (int i = 0; i < NW; i++) dmem[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom()) : gold_m[i];
      do_run(int'($urandom_range(0, 40)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
